// File: rtl/lpif_ustrm_rx_fifo.sv
// lpif_ustrm_rx_fifo: upstream LPIF receive buffer with link-state FSM.
// Optional stats counters: define LPIF_USTRM_RX_STATS_EN.
module lpif_ustrm_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_wr,
    input  logic          rst_wr,
    input  logic          rx_online,
    input  logic [3:0]    ustrm_state,
    input  logic [1:0]    ustrm_protid,
    input  logic [511:0]  ustrm_data,
    input  logic          ustrm_dvalid,
    input  logic [15:0]   ustrm_crc,
    input  logic          ustrm_crc_valid,
    input  logic          ustrm_valid,
    output logic          pl_valid,
    input  logic          pl_ready,
    output logic [511:0]  pl_data,
    output logic [1:0]    pl_protid,
    output logic [15:0]   pl_crc,
    output logic          pl_crc_valid,
    output logic          link_active,
    output logic          state_chg,
    output logic [LW-1:0] fifo_level,
    output logic [15:0]   ovf_cnt,
    output logic [31:0]   flit_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 531;
    localparam logic [3:0] ST_ACT  = 4'b0001;
    localparam logic [3:0] ST_LRST = 4'b1001;

    typedef enum logic [1:0] {
        S_OFFLINE,
        S_IDLE,
        S_ACTIVE,
        S_FLUSH
    } fsm_e;

    fsm_e            fsm;
    fsm_e            nxt;
    logic [3:0]      st_q;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   head;
    logic            push;
    logic            pop;
    logic            full;
    logic            wr;

    // Next link state from the online qualifier and the LPIF state
    always_comb begin
        nxt = fsm;
        unique case (fsm)
            S_OFFLINE: if (rx_online) nxt = S_IDLE;
            S_IDLE: begin
                if (!rx_online || ustrm_state == ST_LRST) nxt = S_FLUSH;
                else if (ustrm_state == ST_ACT)           nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!rx_online || ustrm_state == ST_LRST) nxt = S_FLUSH;
                else if (ustrm_state != ST_ACT)           nxt = S_IDLE;
            end
            S_FLUSH: nxt = rx_online ? S_IDLE : S_OFFLINE;
        endcase
    end

    // A flit is only taken while the link stays active through this cycle,
    // so beats coinciding with a flush or a retrain are discarded.
    assign push = (fsm == S_ACTIVE) && (nxt == S_ACTIVE)
                && ustrm_valid && ustrm_dvalid;
    assign full = (level == LW'(DEPTH));
    assign pl_valid = (level != '0);
    assign pop  = pl_valid && pl_ready;
    assign wr   = push && (!full || pop);

    // FSM state, registered status outputs and captured link state
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            fsm         <= S_OFFLINE;
            st_q        <= 4'b0000;
            state_chg   <= 1'b0;
            link_active <= 1'b0;
        end else begin
            fsm         <= nxt;
            st_q        <= ustrm_state;
            state_chg   <= rx_online && (ustrm_state != st_q);
            link_active <= (nxt == S_ACTIVE);
        end
    end

    // Pointer and occupancy tracking; flush empties the buffer
    always_ff @(posedge clk_wr) begin
        if (rst_wr || fsm == S_FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr);
            rd_ptr <= rd_ptr + AW'(pop);
            level  <= level + LW'(wr) - LW'(pop);
        end
    end

    // Entry storage, not reset: contents are qualified by level
    always_ff @(posedge clk_wr) begin
        if (wr) begin
            mem[wr_ptr] <= {ustrm_crc_valid, ustrm_crc,
                            ustrm_protid, ustrm_data};
        end
    end

    assign head = pl_valid ? mem[rd_ptr] : '0;
    assign {pl_crc_valid, pl_crc, pl_protid, pl_data} = head;
    assign fifo_level = level;

`ifdef LPIF_USTRM_RX_STATS_EN
    logic        drop;
    logic [15:0] ovf_q;
    logic [31:0] flit_q;

    assign drop = push && full && !pop;

    // Saturating drop counter and wrapping accepted-flit counter
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            ovf_q  <= '0;
            flit_q <= '0;
        end else begin
            if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
            if (wr) flit_q <= flit_q + 32'd1;
        end
    end

    assign ovf_cnt  = ovf_q;
    assign flit_cnt = flit_q;
`else
    assign ovf_cnt  = '0;
    assign flit_cnt = '0;
`endif

endmodule

// File: tb/tb_lpif_ustrm_rx_fifo.sv
// tb_lpif_ustrm_rx_fifo: directed scoreboard bench for lpif_ustrm_rx_fifo.
// Delivered entries are checked against a queue filled at drive time.
module tb_lpif_ustrm_rx_fifo;

    logic          clk_wr = 0;
    logic          rst_wr;
    logic          rx_online;
    logic [3:0]    ustrm_state;
    logic [1:0]    ustrm_protid;
    logic [511:0]  ustrm_data;
    logic          ustrm_dvalid;
    logic [15:0]   ustrm_crc;
    logic          ustrm_crc_valid;
    logic          ustrm_valid;
    logic          pl_valid;
    logic          pl_ready;
    logic [511:0]  pl_data;
    logic [1:0]    pl_protid;
    logic [15:0]   pl_crc;
    logic          pl_crc_valid;
    logic          link_active;
    logic          state_chg;
    logic [2:0]    fifo_level;
    logic [15:0]   ovf_cnt;
    logic [31:0]   flit_cnt;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic [530:0] q[$];

`ifdef LPIF_USTRM_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    lpif_ustrm_rx_fifo #(.DEPTH(4)) dut (
        .clk_wr          (clk_wr),
        .rst_wr          (rst_wr),
        .rx_online       (rx_online),
        .ustrm_state     (ustrm_state),
        .ustrm_protid    (ustrm_protid),
        .ustrm_data      (ustrm_data),
        .ustrm_dvalid    (ustrm_dvalid),
        .ustrm_crc       (ustrm_crc),
        .ustrm_crc_valid (ustrm_crc_valid),
        .ustrm_valid     (ustrm_valid),
        .pl_valid        (pl_valid),
        .pl_ready        (pl_ready),
        .pl_data         (pl_data),
        .pl_protid       (pl_protid),
        .pl_crc          (pl_crc),
        .pl_crc_valid    (pl_crc_valid),
        .link_active     (link_active),
        .state_chg       (state_chg),
        .fifo_level      (fifo_level),
        .ovf_cnt         (ovf_cnt),
        .flit_cnt        (flit_cnt)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic chk(input string tag, input logic [530:0] obs,
                       input logic [530:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: score any pop happening at the coming edge, then step past it
    task automatic cyc();
        @(negedge clk_wr);
        if (pl_valid && pl_ready) begin
            chk("pop_expected", 531'(q.size() != 0), 531'(1));
            if (q.size() != 0) begin
                chk("pop_entry",
                    {pl_crc_valid, pl_crc, pl_protid, pl_data}, q[0]);
                void'(q.pop_front());
            end
            pops++;
        end
        @(posedge clk_wr);
        #1;
    endtask

    task automatic send(input logic [511:0] d, input bit exp_acc);
        logic [530:0] e;
        ustrm_valid     = 1'b1;
        ustrm_dvalid    = 1'b1;
        ustrm_data      = d;
        ustrm_protid    = d[1:0];
        ustrm_crc       = d[15:0] ^ 16'hA5A5;
        ustrm_crc_valid = d[0];
        e = {ustrm_crc_valid, ustrm_crc, ustrm_protid, ustrm_data};
        if (exp_acc) q.push_back(e);
        cyc();
    endtask

    task automatic idle_in();
        ustrm_valid  = 1'b0;
        ustrm_dvalid = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_pl_valid", 531'(pl_valid), 531'(0));
        chk("rst_pl_head", {pl_crc_valid, pl_crc, pl_protid, pl_data}, '0);
        chk("rst_link_active", 531'(link_active), 531'(0));
        chk("rst_state_chg", 531'(state_chg), 531'(0));
        chk("rst_level", 531'(fifo_level), 531'(0));
        chk("rst_ovf", 531'(ovf_cnt), 531'(0));
        chk("rst_flit", 531'(flit_cnt), 531'(0));
    endtask

    initial begin
        rst_wr = 1; rx_online = 0; ustrm_state = 4'b0000;
        ustrm_protid = 0; ustrm_data = '0; ustrm_crc = 0;
        ustrm_crc_valid = 0; pl_ready = 0;
        idle_in();
        cyc(); cyc();
        chk_reset_vals();

        // bring link up
        rst_wr = 0; rx_online = 1; ustrm_state = 4'b0001;
        cyc();
        chk("up_state_chg", 531'(state_chg), 531'(1));
        chk("up_not_active_yet", 531'(link_active), 531'(0));
        cyc();
        chk("up_link_active", 531'(link_active), 531'(1));
        chk("up_chg_cleared", 531'(state_chg), 531'(0));

        // basic flow
        pl_ready = 1;
        send(512'h1, 1);
        chk("basic_latency", 531'(pl_valid), 531'(1));
        send(512'h2, 1);
        send(512'h3, 1);
        idle_in();
        cyc(); cyc();
        chk("basic_pops", 531'(pops), 531'(3));
        chk("basic_level", 531'(fifo_level), 531'(0));
        chk("basic_flit", 531'(flit_cnt), 531'(STATS ? 3 : 0));

        // overflow with consumer stalled
        pl_ready = 0;
        send(512'h11, 1);
        send(512'h12, 1);
        send(512'h13, 1);
        send(512'h14, 1);
        send(512'h15, 0);
        send(512'h16, 0);
        idle_in();
        cyc();
        chk("ovf_level", 531'(fifo_level), 531'(4));
        chk("ovf_cnt", 531'(ovf_cnt), 531'(STATS ? 2 : 0));

        // push and pop together while full
        pl_ready = 1;
        send(512'h17, 1);
        pl_ready = 0;
        idle_in();
        chk("full_pp_level", 531'(fifo_level), 531'(4));
        chk("full_pp_ovf", 531'(ovf_cnt), 531'(STATS ? 2 : 0));
        cyc();
        chk("stall_head_stable", 531'(pl_data), 531'(512'h12));
        pl_ready = 1;
        repeat (5) cyc();
        chk("drain_level", 531'(fifo_level), 531'(0));
        chk("drain_pops", 531'(pops), 531'(8));

        // LinkReset flush, with a flit in the transition cycle
        pl_ready = 0;
        send(512'h21, 1);
        send(512'h22, 1);
        ustrm_state = 4'b1001;
        send(512'h23, 0);
        idle_in();
        chk("lr_state_chg", 531'(state_chg), 531'(1));
        chk("lr_link_active", 531'(link_active), 531'(0));
        chk("lr_valid_in_flush", 531'(pl_valid), 531'(1));
        q.delete();
        cyc();
        chk("lr_flushed_valid", 531'(pl_valid), 531'(0));
        chk("lr_flushed_level", 531'(fifo_level), 531'(0));
        chk("lr_no_ovf", 531'(ovf_cnt), 531'(STATS ? 2 : 0));
        ustrm_state = 4'b0001;
        cyc();
        chk("lr_back_active", 531'(link_active), 531'(1));

        // retrain keeps buffered entries, rejects the new beat
        send(512'h31, 1);
        send(512'h32, 1);
        ustrm_state = 4'b1011;
        send(512'h33, 0);
        idle_in();
        chk("rt_link_active", 531'(link_active), 531'(0));
        chk("rt_level", 531'(fifo_level), 531'(2));
        pl_ready = 1;
        repeat (3) cyc();
        chk("rt_pops", 531'(pops), 531'(10));
        chk("rt_level_empty", 531'(fifo_level), 531'(0));

        // reset with entries buffered
        ustrm_state = 4'b0001;
        pl_ready = 0;
        cyc();
        send(512'h41, 1);
        send(512'h42, 1);
        send(512'h43, 1);
        idle_in();
        chk("mid_level", 531'(fifo_level), 531'(3));
        chk("mid_flit", 531'(flit_cnt), 531'(STATS ? 15 : 0));
        rst_wr = 1;
        q.delete();
        cyc();
        chk_reset_vals();
        chk("rst_queue_empty", 531'(q.size()), 531'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
